// File: rtl/pacman_dir_queue_if.sv
// Handshake bundle between the button debouncers/game logic and the direction queue.
interface pacman_dir_queue_if #(parameter int DEPTH = 4);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          BTNU_SCEN;
    logic          BTNR_SCEN;
    logic          BTND_SCEN;
    logic          BTNL_SCEN;
    logic          MOVE_TICK;
    logic          CLEAR;
    logic [1:0]    DIR;
    logic          DIR_VALID;
    logic [CW-1:0] Q_COUNT;
    logic          FULL;
    logic          EMPTY;
    logic          OVERFLOW;

    modport master (
        output BTNU_SCEN, BTNR_SCEN, BTND_SCEN, BTNL_SCEN, MOVE_TICK, CLEAR,
        input  DIR, DIR_VALID, Q_COUNT, FULL, EMPTY, OVERFLOW
    );

    modport slave (
        input  BTNU_SCEN, BTNR_SCEN, BTND_SCEN, BTNL_SCEN, MOVE_TICK, CLEAR,
        output DIR, DIR_VALID, Q_COUNT, FULL, EMPTY, OVERFLOW
    );
endinterface

// File: rtl/pacman_dir_queue.sv
// Buffered Pac-Man heading queue: button presses queue up, MOVE_TICK applies the next one.
// Optional macro PACMAN_REVERSE_BYPASS_EN: an immediate reversal flushes the queue and turns at once.
module pacman_dir_queue #(
    parameter int DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    pacman_dir_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {NOHEAD, RUN} state_t;

    state_t        state;
    logic [1:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, tail_ptr;
    logic [CW-1:0] count;
    logic [1:0]    dir;
    logic          dir_valid;
    logic          overflow;

    logic          cand_vld, multi_lost, dup, surv, rev, full, empty;
    logic          push, pop, ovf_set;
    logic [1:0]    cand;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign tail_ptr = wr_ptr - PW'(1);

    always_comb begin
        cand_vld   = bus.BTNU_SCEN | bus.BTNR_SCEN | bus.BTND_SCEN | bus.BTNL_SCEN;
        multi_lost = (bus.BTNU_SCEN & (bus.BTNR_SCEN | bus.BTND_SCEN | bus.BTNL_SCEN)) |
                     (bus.BTNR_SCEN & (bus.BTND_SCEN | bus.BTNL_SCEN)) |
                     (bus.BTND_SCEN & bus.BTNL_SCEN);
        if (bus.BTNU_SCEN)      cand = 2'b00;
        else if (bus.BTNR_SCEN) cand = 2'b01;
        else if (bus.BTND_SCEN) cand = 2'b10;
        else                    cand = 2'b11;

        // Repeating the last queued (or current, if queue empty) heading is a no-op, not a loss.
        dup  = empty ? (dir_valid && cand == dir) : (cand == mem[tail_ptr]);
        surv = cand_vld && !dup;
        pop  = bus.MOVE_TICK && !empty;
`ifdef PACMAN_REVERSE_BYPASS_EN
        rev  = surv && (state == RUN) && (cand == {~dir[1], dir[0]});
`else
        rev  = 1'b0;
`endif
        push    = surv && !rev && (!full || pop);
        ovf_set = multi_lost || (surv && !rev && full && !pop);
    end

    // Storage is not reset; only pointers and count define occupancy.
    always_ff @(posedge CLK) begin
        if (RESET && push && !bus.CLEAR)
            mem[wr_ptr] <= cand;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= NOHEAD;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            dir       <= 2'b00;
            dir_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (ovf_set)         overflow <= 1'b1;
            else if (bus.CLEAR)  overflow <= 1'b0;

            if (bus.CLEAR) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else if (rev) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                dir    <= cand;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop) begin
                    dir       <= mem[rd_ptr];
                    rd_ptr    <= rd_ptr + PW'(1);
                    dir_valid <= 1'b1;
                    state     <= RUN;
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    assign bus.DIR       = dir;
    assign bus.DIR_VALID = dir_valid;
    assign bus.Q_COUNT   = count;
    assign bus.FULL      = full;
    assign bus.EMPTY     = empty;
    assign bus.OVERFLOW  = overflow;
endmodule

// File: tb/tb_pacman_dir_queue.sv
// Self-checking bench for pacman_dir_queue: directed table, corner sequences, random vs queue model.
module tb_pacman_dir_queue;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    pacman_dir_queue_if #(.DEPTH(DEPTH)) bus ();
    pacman_dir_queue #(.DEPTH(DEPTH)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: the queue as a plain SV queue of headings.
    int         mq[$];
    logic [1:0] mdir;
    bit         mdv, movf;

    typedef struct {
        logic [5:0] in;   // {U,R,D,L,TICK,CLEAR}
        logic [1:0] dir;
        bit         dv;
        int         cnt;
        bit         ovf;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic model_update(input logic [5:0] in, input bit rst);
        int n, cand;
        bit full, popping, survive, rev, floss;
        if (!rst) begin
            mq.delete(); mdir = 2'b00; mdv = 0; movf = 0;
            return;
        end
        n = int'(in[5]) + int'(in[4]) + int'(in[3]) + int'(in[2]);
        cand = in[5] ? 0 : in[4] ? 1 : in[3] ? 2 : 3;
        full = (mq.size() == DEPTH);
        popping = in[1] && (mq.size() > 0);
        survive = (n > 0) && ((mq.size() > 0) ? (mq[$] != cand) : !(mdv && int'(mdir) == cand));
        rev = 0;
`ifdef PACMAN_REVERSE_BYPASS_EN
        rev = survive && mdv && (int'(mdir ^ 2'b10) == cand);
`endif
        floss = survive && !rev && full && !popping;
        if (in[0]) begin
            mq.delete();
            movf = (n > 1) || floss;
        end else if (rev) begin
            mq.delete();
            mdir = 2'(cand);
            if (n > 1) movf = 1;
        end else begin
            if (n > 1 || floss) movf = 1;
            if (popping) begin
                mdir = 2'(mq.pop_front());
                mdv = 1;
            end
            if (survive && !floss) mq.push_back(cand);
        end
    endtask

    task automatic step(input logic [5:0] in, input bit rst = 1'b1);
        RESET = rst;
        {bus.BTNU_SCEN, bus.BTNR_SCEN, bus.BTND_SCEN, bus.BTNL_SCEN, bus.MOVE_TICK, bus.CLEAR} = in;
        model_update(in, rst);
        @(posedge CLK);
        #1;
        {bus.BTNU_SCEN, bus.BTNR_SCEN, bus.BTND_SCEN, bus.BTNL_SCEN, bus.MOVE_TICK, bus.CLEAR} = '0;
        RESET = 1'b1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".dir"},   int'(bus.DIR),       int'(mdir));
        chk({tag, ".dv"},    int'(bus.DIR_VALID), int'(mdv));
        chk({tag, ".cnt"},   int'(bus.Q_COUNT),   mq.size());
        chk({tag, ".full"},  int'(bus.FULL),      int'(mq.size() == DEPTH));
        chk({tag, ".empty"}, int'(bus.EMPTY),     int'(mq.size() == 0));
        chk({tag, ".ovf"},   int'(bus.OVERFLOW),  int'(movf));
    endtask

    localparam logic [5:0] U = 6'b100000, R = 6'b010000, D = 6'b001000,
                           L = 6'b000100, T = 6'b000010, C = 6'b000001, N = 6'b000000;

    initial begin
        // Hand-derived expectations for the default build, starting from reset.
        tbl[0]  = '{R,     2'd0, 1'b0, 1, 1'b0};
        tbl[1]  = '{T,     2'd1, 1'b1, 0, 1'b0};
        tbl[2]  = '{T,     2'd1, 1'b1, 0, 1'b0};
        tbl[3]  = '{R,     2'd1, 1'b1, 0, 1'b0};
        tbl[4]  = '{R,     2'd1, 1'b1, 0, 1'b0};
        tbl[5]  = '{U,     2'd1, 1'b1, 1, 1'b0};
        tbl[6]  = '{R,     2'd1, 1'b1, 2, 1'b0};
        tbl[7]  = '{D,     2'd1, 1'b1, 3, 1'b0};
        tbl[8]  = '{L,     2'd1, 1'b1, 4, 1'b0};
        tbl[9]  = '{U,     2'd1, 1'b1, 4, 1'b1};
        tbl[10] = '{T,     2'd0, 1'b1, 3, 1'b1};
        tbl[11] = '{T,     2'd1, 1'b1, 2, 1'b1};
        tbl[12] = '{T,     2'd2, 1'b1, 1, 1'b1};
        tbl[13] = '{T,     2'd3, 1'b1, 0, 1'b1};
        tbl[14] = '{C,     2'd3, 1'b1, 0, 1'b0};
        tbl[15] = '{U | L, 2'd3, 1'b1, 1, 1'b1};
        tbl[16] = '{T,     2'd0, 1'b1, 0, 1'b1};

        {bus.BTNU_SCEN, bus.BTNR_SCEN, bus.BTND_SCEN, bus.BTNL_SCEN, bus.MOVE_TICK, bus.CLEAR} = '0;
        step(N, 1'b0);
        step(U | T, 1'b0);
        chk("rst.dir",   int'(bus.DIR), 0);
        chk("rst.dv",    int'(bus.DIR_VALID), 0);
        chk("rst.cnt",   int'(bus.Q_COUNT), 0);
        chk("rst.empty", int'(bus.EMPTY), 1);
        chk("rst.full",  int'(bus.FULL), 0);
        chk("rst.ovf",   int'(bus.OVERFLOW), 0);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].in);
            chk($sformatf("tbl%0d.dir", i), int'(bus.DIR), int'(tbl[i].dir));
            chk($sformatf("tbl%0d.dv", i),  int'(bus.DIR_VALID), int'(tbl[i].dv));
            chk($sformatf("tbl%0d.cnt", i), int'(bus.Q_COUNT), tbl[i].cnt);
            chk($sformatf("tbl%0d.full", i), int'(bus.FULL), int'(tbl[i].cnt == DEPTH));
            chk($sformatf("tbl%0d.ovf", i), int'(bus.OVERFLOW), int'(tbl[i].ovf));
        end

        // Full queue: push and pop on the same edge, then drain to see the wrapped tail.
        step(R); step(D); step(L); step(U);
        chk("full.cnt", int'(bus.Q_COUNT), 4);
        chk("full.flag", int'(bus.FULL), 1);
        step(R | T);
        chk("pushpop.cnt", int'(bus.Q_COUNT), 4);
        chk("pushpop.dir", int'(bus.DIR), 1);
        step(T); chk("drain0", int'(bus.DIR), 2);
        step(T); chk("drain1", int'(bus.DIR), 3);
        step(T); chk("drain2", int'(bus.DIR), 0);
        step(T); chk("drain3.wrapped_tail", int'(bus.DIR), 1);
        chk("drain.empty", int'(bus.EMPTY), 1);

        // Reversal against current heading with two entries queued.
        step(N, 1'b0);
        step(U); step(T); step(R); step(L);
        chk("rev.pre_cnt", int'(bus.Q_COUNT), 2);
        step(D);
`ifdef PACMAN_REVERSE_BYPASS_EN
        chk("rev.dir", int'(bus.DIR), 2);
        chk("rev.cnt", int'(bus.Q_COUNT), 0);
`else
        chk("rev.dir", int'(bus.DIR), 0);
        chk("rev.cnt", int'(bus.Q_COUNT), 3);
`endif
        cmp_model("rev");

        // Mid-operation reset discards queued entries.
        step(R | T, 1'b0);
        cmp_model("midrst");

        for (int i = 0; i < 1500; i++) begin
            logic [5:0] in;
            bit rst;
            in[5] = ($urandom_range(0, 3) == 0);
            in[4] = ($urandom_range(0, 3) == 0);
            in[3] = ($urandom_range(0, 3) == 0);
            in[2] = ($urandom_range(0, 3) == 0);
            in[1] = ($urandom_range(0, 2) == 0);
            in[0] = ($urandom_range(0, 29) == 0);
            rst   = ($urandom_range(0, 99) != 0);
            step(in, rst);
            cmp_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pacman_dir_queue.md
PACMAN_DIR_QUEUE -- requirements
Module: pacman_dir_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the queue depth in entries; legal values are 2, 4 and 8.
REQ-002 Port CLK, input, 1 bit, SHALL be the system clock (100 MHz); all state updates occur on its rising edge.
REQ-003 Port RESET, input, 1 bit, SHALL be the reset: synchronous, active-low.
REQ-004 Ports BTNU_SCEN, BTNR_SCEN, BTND_SCEN and BTNL_SCEN, input, 1 bit each, SHALL be single-clock press pulses from the four direction-button debouncers.
REQ-005 Port MOVE_TICK, input, 1 bit, SHALL be a one-clock request from game logic to consume the next queued direction.
REQ-006 Port CLEAR, input, 1 bit, SHALL flush the queue and clear OVERFLOW while preserving DIR and DIR_VALID.
REQ-007 Port DIR, output, 2 bits, SHALL carry the current heading: 00 = up, 01 = right, 10 = down, 11 = left.
REQ-008 Port DIR_VALID, output, 1 bit, SHALL be high once any heading has been applied.
REQ-009 Port Q_COUNT, output, $clog2(DEPTH)+1 bits, SHALL give the number of occupied entries.
REQ-010 Ports FULL and EMPTY, output, 1 bit each, SHALL be high when Q_COUNT is DEPTH or 0, respectively.
REQ-011 Port OVERFLOW, output, 1 bit, SHALL be a sticky flag set when a press is lost.

Function
REQ-012 The block SHALL form one candidate direction per cycle from the pulses, with priority U > R > D > L; lower-priority simultaneous pulses are lost and SHALL set OVERFLOW.
REQ-013 A candidate equal to the tail entry, or equal to DIR when the queue is empty and DIR_VALID=1, SHALL be discarded without setting OVERFLOW.
REQ-014 A surviving candidate SHALL be written at the tail on the same edge and SHALL be reflected in Q_COUNT one cycle after the pulse.
REQ-015 A push SHALL be discarded, and OVERFLOW set, when FULL=1 and no pop occurs in the same cycle.
REQ-016 When MOVE_TICK=1 and EMPTY=0, the head entry SHALL load into DIR, set DIR_VALID and be removed, with DIR updated one cycle after the tick.
REQ-017 When MOVE_TICK=1 and EMPTY=1, DIR SHALL hold and nothing else SHALL change.
REQ-018 A simultaneous push and pop SHALL both succeed, including when FULL=1; Q_COUNT then stays unchanged.
REQ-019 A push into an empty queue SHALL NOT bypass to DIR in the same cycle; it becomes poppable on the next tick.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH; Q_COUNT SHALL never exceed DEPTH or underflow below 0.
REQ-021 The control FSM SHALL have states NOHEAD (DIR_VALID=0) and RUN.
REQ-022 NOHEAD SHALL move to RUN on the first successful pop; RUN SHALL leave only on reset.
REQ-023 CLEAR SHALL take priority over a same-cycle push and pop: pointers and count go to 0, and OVERFLOW goes to 0 unless a loss occurs in that same cycle.

Reset
REQ-024 When RESET=0 at a rising edge, the block SHALL set DIR=00, DIR_VALID=0, Q_COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0 and FSM=NOHEAD.
REQ-025 Queue storage contents need not be reset.
REQ-026 A reset asserted mid-operation SHALL discard all queued entries, with no pop or push completing on that edge.

Configuration
REQ-027 With macro PACMAN_REVERSE_BYPASS_EN defined, a surviving candidate that is the exact opposite of DIR while in RUN SHALL flush the queue and load DIR on the same edge, with OVERFLOW unaffected.
REQ-028 With PACMAN_REVERSE_BYPASS_EN undefined, such a candidate SHALL be queued like any other.

Verification
REQ-029 Reset, then pulse BTNR_SCEN and then MOVE_TICK: Q_COUNT goes 0->1->0, DIR=01 and DIR_VALID=1 one cycle after the tick.
REQ-030 With DEPTH=4, push U,R,D,L,U without pops: FULL=1 after the 4th push, the 5th push sets OVERFLOW=1, and pops return 00,01,10,11.
REQ-031 Assert BTNU_SCEN and BTNL_SCEN in the same cycle: only 00 is queued and OVERFLOW=1.
REQ-032 With FULL=1, assert a push and MOVE_TICK in the same cycle: Q_COUNT stays 4, and the wrapped tail holds the new direction.
REQ-033 Press R twice with the queue empty and DIR=01: Q_COUNT stays 0 and OVERFLOW stays 0.
REQ-034 With the macro defined, DIR=00 and two entries queued, pulse BTND_SCEN: DIR=10 and Q_COUNT=0 the next cycle; without the macro, Q_COUNT=3.
